// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase accumulator: default widths, the
// controller state encoding and the phase-offset-to-address helper.
package dds_pkg;

    localparam int ACC_W_DEF      = 32;
    localparam int FREQ_SHIFT_DEF = 8;
    localparam int ADDR_W         = 16;
    localparam int FREQ_W         = 12;
    localparam int PHASE_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } dds_state_e;

    // A phase offset is in 1/256 period units, so it occupies the top byte
    // of the lookup address.
    function automatic logic [ADDR_W-1:0] phase_to_addr(input logic [PHASE_W-1:0] ph);
        return {ph, 8'h00};
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep step: computes the next active frequency code taken at a
// period boundary. Only present in builds with DDS_SWEEP_EN defined.
`ifdef DDS_SWEEP_EN
module dds_sweep_ctrl
    import dds_pkg::*;
(
    input  logic [FREQ_W-1:0] freq_cur,
    input  logic [FREQ_W-1:0] freq_base,
    input  logic [FREQ_W-1:0] step,
    input  logic [FREQ_W-1:0] lim,
    output logic [FREQ_W-1:0] freq_next
);

    // One bit of headroom so an overflowing step still compares above the limit.
    logic [FREQ_W:0] sum_s;

    assign sum_s = {1'b0, freq_cur} + {1'b0, step};

    // Advance by the step, falling back to the base code once the limit is reached.
    always_comb begin
        freq_next = freq_cur;
        if (step == {FREQ_W{1'b0}}) begin
            freq_next = freq_cur;
        end else if (sum_s >= {1'b0, lim}) begin
            freq_next = freq_base;
        end else begin
            freq_next = sum_s[FREQ_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/phase_acc.sv
// DDS phase accumulator with start/stop control at period boundaries and
// glitch-free (boundary-aligned) frequency/phase updates.
// Optional build macro DDS_SWEEP_EN adds a per-period frequency sweep.
module phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int FREQ_SHIFT = FREQ_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               load,
    input  logic [FREQ_W-1:0]  state_freq,
    input  logic [PHASE_W-1:0] state_phase,
    input  logic               sync_clr,
`ifdef DDS_SWEEP_EN
    input  logic [FREQ_W-1:0]  sweep_step,
    input  logic [FREQ_W-1:0]  sweep_lim,
`endif
    output logic [ADDR_W-1:0]  addr,
    output logic               en,
    output logic               wrap,
    output logic               pending
);

    localparam int TW_RAW_W = FREQ_W + FREQ_SHIFT;

    dds_state_e          state_r;
    dds_state_e          state_nxt_s;
    logic [ACC_W-1:0]    acc_r;
    logic [FREQ_W-1:0]   freq_act_r;
    logic [PHASE_W-1:0]  ph_act_r;
    logic [FREQ_W-1:0]   freq_sh_r;
    logic [PHASE_W-1:0]  ph_sh_r;
    logic [FREQ_W-1:0]   freq_wrap_s;
    logic [TW_RAW_W-1:0] tw_raw_s;
    logic [ACC_W-1:0]    tw_s;
    logic [ACC_W:0]      sum_s;
    logic [ADDR_W-1:0]   acc_top_s;
    logic                active_s;
    logic                wrap_evt_s;
    logic                tw_zero_s;
    logic                apply_now_s;

    assign tw_raw_s    = TW_RAW_W'(freq_act_r) << FREQ_SHIFT;
    assign tw_s        = ACC_W'(tw_raw_s);
    assign tw_zero_s   = (tw_s == {ACC_W{1'b0}});
    assign sum_s       = {1'b0, acc_r} + {1'b0, tw_s};
    assign acc_top_s   = acc_r[ACC_W-1 -: ADDR_W];
    assign active_s    = (state_r != ST_IDLE);
    // A clear in the same cycle suppresses the addition, so it cannot carry.
    assign wrap_evt_s  = active_s && !sync_clr && sum_s[ACC_W];
    // With no increment there is no boundary to wait for, so loads land at once.
    assign apply_now_s = !active_s || wrap_evt_s || tw_zero_s;

`ifdef DDS_SWEEP_EN
    logic [FREQ_W-1:0] freq_base_r;
    logic [FREQ_W-1:0] freq_swept_s;

    dds_sweep_ctrl u_sweep (
        .freq_cur  (freq_act_r),
        .freq_base (freq_base_r),
        .step      (sweep_step),
        .lim       (sweep_lim),
        .freq_next (freq_swept_s)
    );

    assign freq_wrap_s = (state_r == ST_RUN) ? freq_swept_s : freq_act_r;
`else
    assign freq_wrap_s = freq_act_r;
`endif

    // Next controller state: stopping only completes at a period boundary.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) state_nxt_s = ST_RUN;
                else     state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (run) state_nxt_s = ST_RUN;
                else     state_nxt_s = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (run)                          state_nxt_s = ST_RUN;
                else if (wrap_evt_s || tw_zero_s) state_nxt_s = ST_IDLE;
                else                              state_nxt_s = ST_STOPPING;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state, accumulator and registered lookup-stage outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            addr    <= {ADDR_W{1'b0}};
            en      <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (sync_clr || state_nxt_s == ST_IDLE || !active_s) begin
                acc_r <= {ACC_W{1'b0}};
            end else begin
                acc_r <= sum_s[ACC_W-1:0];
            end
            wrap <= wrap_evt_s;
            en   <= active_s;
            if (active_s) begin
                addr <= acc_top_s + phase_to_addr(ph_act_r);
            end else begin
                addr <= {ADDR_W{1'b0}};
            end
        end
    end

    // Active and shadow tuning registers; shadow values wait for a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_act_r  <= {FREQ_W{1'b0}};
            ph_act_r    <= {PHASE_W{1'b0}};
            freq_sh_r   <= {FREQ_W{1'b0}};
            ph_sh_r     <= {PHASE_W{1'b0}};
            pending     <= 1'b0;
`ifdef DDS_SWEEP_EN
            freq_base_r <= {FREQ_W{1'b0}};
`endif
        end else if (load) begin
            if (apply_now_s) begin
                freq_act_r  <= state_freq;
                ph_act_r    <= state_phase;
                pending     <= 1'b0;
`ifdef DDS_SWEEP_EN
                freq_base_r <= state_freq;
`endif
            end else begin
                freq_sh_r <= state_freq;
                ph_sh_r   <= state_phase;
                pending   <= 1'b1;
            end
        end else if (wrap_evt_s) begin
            if (pending) begin
                freq_act_r  <= freq_sh_r;
                ph_act_r    <= ph_sh_r;
                pending     <= 1'b0;
`ifdef DDS_SWEEP_EN
                freq_base_r <= freq_sh_r;
`endif
            end else begin
                freq_act_r <= freq_wrap_s;
            end
        end
    end

endmodule

// File: tb/tb_phase_acc.sv
// Scoreboard bench for phase_acc: a cycle model built from plain integer
// arithmetic predicts each valid output; a monitor pops and compares.
module tb_phase_acc;

    localparam int    ACC_W = 24;
    localparam longint MOD  = 64'd1 << ACC_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        load = 1'b0;
    logic        sync_clr = 1'b0;
    logic [11:0] state_freq = 12'd0;
    logic [7:0]  state_phase = 8'd0;
    logic [15:0] addr;
    logic        en;
    logic        wrap;
    logic        pending;
`ifdef DDS_SWEEP_EN
    logic [11:0] sweep_step = 12'd0;
    logic [11:0] sweep_lim  = 12'hFFF;
`endif

    phase_acc #(.ACC_W(ACC_W), .FREQ_SHIFT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .load        (load),
        .state_freq  (state_freq),
        .state_phase (state_phase),
        .sync_clr    (sync_clr),
`ifdef DDS_SWEEP_EN
        .sweep_step  (sweep_step),
        .sweep_lim   (sweep_lim),
`endif
        .addr        (addr),
        .en          (en),
        .wrap        (wrap),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] addr;
        logic        wrap;
        logic        pending;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 finishing the current period.
    int     m_mode = 0;
    longint m_acc = 0;
    int     m_freq = 0, m_ph = 0, m_sfreq = 0, m_sph = 0;
    bit     m_pend = 1'b0;
    longint m_tw, m_nxt;
    bit     m_running, m_carry;
    int     m_nmode;
    exp_t   m_e;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_acc = 0; m_freq = 0; m_ph = 0;
            m_sfreq = 0; m_sph = 0; m_pend = 1'b0;
            sb_q.delete();
        end else begin
            m_tw      = (longint'(m_freq) * 256) % MOD;
            m_running = (m_mode != 0);
            m_nxt     = m_acc + m_tw;
            m_carry   = m_running && !sync_clr && (m_nxt >= MOD);
            if (m_mode == 0)      m_nmode = run ? 1 : 0;
            else if (m_mode == 1) m_nmode = run ? 1 : 2;
            else                  m_nmode = run ? 1 : ((m_carry || m_tw == 0) ? 0 : 2);
            m_e.addr = 16'((m_acc >> 8) + longint'(m_ph) * 256);
            m_e.wrap = m_carry;
            if (load) begin
                if (!m_running || m_carry || m_tw == 0) begin
                    m_freq = int'(state_freq); m_ph = int'(state_phase); m_pend = 1'b0;
                end else begin
                    m_sfreq = int'(state_freq); m_sph = int'(state_phase); m_pend = 1'b1;
                end
            end else if (m_carry && m_pend) begin
                m_freq = m_sfreq; m_ph = m_sph; m_pend = 1'b0;
            end
            if (sync_clr || m_nmode == 0 || !m_running) m_acc = 0;
            else                                        m_acc = m_nxt % MOD;
            m_mode = m_nmode;
            if (m_running) begin
                m_e.pending = m_pend;
                sb_q.push_back(m_e);
            end
        end
    end

    // Monitor: compare every presented output against the scoreboard.
    initial forever begin
        exp_t got;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (en) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_en", 32'(en), 32'd0);
                end else begin
                    got = sb_q.pop_front();
                    chk("sb_addr", 32'(addr), 32'(got.addr));
                    chk("sb_wrap", 32'(wrap), 32'(got.wrap));
                    chk("sb_pending", 32'(pending), 32'(got.pending));
                end
            end else begin
                if (sb_q.size() != 0) begin
                    chk("sb_missing_en", 32'(en), 32'd1);
                    void'(sb_q.pop_front());
                end
                chk("idle_addr", 32'(addr), 32'd0);
                chk("idle_wrap", 32'(wrap), 32'd0);
                chk("idle_pending", 32'(pending), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; load = 1'b0; sync_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_wrap(input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (wrap) break;
        end
        chk(name, 32'(wrap), 32'd1);
    endtask

    initial begin
        int hold = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Phase offset loaded in idle shows on the first valid address
        @(negedge clk);
        load = 1'b1; state_freq = 12'h100; state_phase = 8'h40; run = 1'b1;
        @(posedge clk); #1;
        chk("start_en_lat1", 32'(en), 32'd0);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk); #1;
        chk("start_en", 32'(en), 32'd1);
        chk("start_addr", 32'(addr), 32'h4000);
        @(posedge clk); #1;
        chk("start_addr_step", 32'(addr), 32'h4100);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                run  = ($urandom_range(0, 9) != 0);
                hold = $urandom_range(20, 400);
            end
            hold--;
            load = ($urandom_range(0, 29) == 0);
            if (load) begin
                state_freq  = ($urandom_range(0, 19) == 0) ? 12'd0 : 12'($urandom_range(200, 4095));
                state_phase = 8'($urandom);
            end
            sync_clr = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        load = 1'b0; sync_clr = 1'b0;

        // Mid-period update waits for the boundary, then stop at next boundary
        do_reset();
        @(negedge clk);
        load = 1'b1; state_freq = 12'h100; state_phase = 8'h00; run = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        load = 1'b1; state_freq = 12'h080; state_phase = 8'h10;
        @(posedge clk); #1;
        chk("pending_set", 32'(pending), 32'd1);
        @(negedge clk);
        load = 1'b0;
        wait_wrap(300, "wrap_pending");
        chk("wrap_addr", 32'(addr), 32'hFF00);
        chk("pending_clr", 32'(pending), 32'd0);
        @(posedge clk); #1;
        chk("new_phase_addr", 32'(addr), 32'h1000);
        @(posedge clk); #1;
        chk("new_step_addr", 32'(addr), 32'h1080);
        @(negedge clk);
        run = 1'b0;
        wait_wrap(600, "wrap_stop");
        chk("en_until_wrap", 32'(en), 32'd1);
        @(posedge clk); #1;
        chk("stop_en", 32'(en), 32'd0);
        chk("stop_addr", 32'(addr), 32'd0);

        // Asynchronous reset while an update is pending
        @(negedge clk);
        load = 1'b1; state_freq = 12'h100; state_phase = 8'h22; run = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);
        load = 1'b1; state_freq = 12'h010;
        @(posedge clk); #1;
        chk("pending_set2", 32'(pending), 32'd1);
        @(negedge clk);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(en), 32'd0);
        chk("arst_addr", 32'(addr), 32'd0);
        chk("arst_wrap", 32'(wrap), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_pending", 32'(pending), 32'd0);
        run = 1'b1;
        repeat (30) @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
